paralelo_serial: RTL

PARALELO_SERIAL -- requirements
Module: paralelo_serial

---
 rtl/paralelo_serial.sv | 106 ++++++++++
 1 files changed

// File: rtl/paralelo_serial.sv
// Parallel-to-serial converter: 4-word FIFO of 2-bit words drained MSB first,
// one bit per cycle, with a sticky overflow flag for words dropped while full.
module paralelo_serial (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] dataIn,
  input  logic       validIN,
  output logic       serialOut,
  output logic       validSerial,
  output logic       empty,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_MSB = 2'd1,
    SEND_LSB = 2'd2
  } stateType;

  stateType   state;
  logic [1:0] mem [4];
  logic [1:0] wrPtr;
  logic [1:0] rdPtr;
  logic [2:0] count;
  logic [2:0] countNext;
  logic [1:0] shiftReg;
  logic [1:0] headWord;
  logic       popEn;
  logic       pushEn;
  logic       dropEn;

  // Pop decisions look at the occupancy before this edge's push, so a word
  // written this cycle can never be popped on the same edge.
  always_comb begin
    headWord  = mem[rdPtr];
    popEn     = ((state == IDLE) || (state == SEND_LSB)) && (count != 3'd0);
    pushEn    = validIN && ((count != 3'd4) || popEn);
    dropEn    = validIN && !pushEn;
    countNext = count;
    case ({pushEn, popEn})
      2'b10:   countNext = count + 3'd1;
      2'b01:   countNext = count - 3'd1;
      default: countNext = count;
    endcase
  end

  // Storage array carries data only; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (pushEn && !reset) begin
      mem[wrPtr] <= dataIn;
    end
  end

  // Control, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wrPtr       <= 2'd0;
      rdPtr       <= 2'd0;
      count       <= 3'd0;
      shiftReg    <= 2'd0;
      overflow    <= 1'b0;
      serialOut   <= 1'b0;
      validSerial <= 1'b0;
      empty       <= 1'b1;
    end else begin
      if (pushEn) begin
        wrPtr <= wrPtr + 2'd1;
      end
      if (popEn) begin
        rdPtr <= rdPtr + 2'd1;
      end
      if (dropEn) begin
        overflow <= 1'b1;
      end
      count <= countNext;
      empty <= (countNext == 3'd0);

      case (state)
        IDLE, SEND_LSB: begin
          if (popEn) begin
            shiftReg    <= headWord;
            state       <= SEND_MSB;
            serialOut   <= headWord[1];
            validSerial <= 1'b1;
          end else begin
            state       <= IDLE;
            serialOut   <= 1'b0;
            validSerial <= 1'b0;
          end
        end
        SEND_MSB: begin
          state       <= SEND_LSB;
          serialOut   <= shiftReg[0];
          validSerial <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          serialOut   <= 1'b0;
          validSerial <= 1'b0;
        end
      endcase
    end
  end

endmodule
